// File: rtl/eq_pkg.sv
// Shared equalizer package: widths, fixed-point formats, decision level,
// saturation limits and the registered result payload.
package eq_pkg;

    localparam int unsigned DATA_BW = 9;            // sample format S(9,7)
    localparam int unsigned COEF_BW = 9;            // tap format S(9,7)
    localparam int unsigned N_COEF  = 7;            // number of taps
    localparam int unsigned Y_BW    = 10;           // equalized sample S(10,7)
    localparam int unsigned ERR_BW  = 8;            // error S(8,7)
    localparam int unsigned FRAC    = 7;            // fractional bits of y/e
    localparam int unsigned ACC_BW  = 21;           // sum S(21,14)
    localparam int unsigned PROD_BW = DATA_BW + COEF_BW;  // product S(18,14)
    localparam int unsigned DIFF_BW = Y_BW + 1;     // y - d before saturation, S(11,7)
    localparam int unsigned FILL_BW = $clog2(N_COEF + 1);

    localparam int ONE     = 128;                   // +1.0 in S(.,7)
    localparam int Y_MAX   = 511;
    localparam int Y_MIN   = -512;
    localparam int ERR_MAX = 127;
    localparam int ERR_MIN = -128;

    // Stage-3 result word
    typedef struct packed {
        logic [Y_BW-1:0]   y;
        logic              sym;
        logic [ERR_BW-1:0] err;
    } ffe_res_t;

endpackage

// File: rtl/ffe_slicer_if.sv
// Sample/coefficient inputs and equalizer result outputs of ffe_slicer.
//   i_en/i_data : sample strobe and received sample x(n), S(9,7)
//   i_coefs     : packed taps, tap k at [COEF_BW*(k+1)-1 : COEF_BW*k]
//   o_y/o_sym/o_error/o_valid : equalized sample, decision, error, qualifier
interface ffe_slicer_if import eq_pkg::*; ();

    logic                              i_en;
    logic signed [DATA_BW-1:0]         i_data;
    logic        [COEF_BW*N_COEF-1:0]  i_coefs;
    logic signed [Y_BW-1:0]            o_y;
    logic                              o_sym;
    logic signed [ERR_BW-1:0]          o_error;
    logic                              o_valid;

    modport master (
        output i_en, i_data, i_coefs,
        input  o_y, o_sym, o_error, o_valid
    );

    modport slave (
        input  i_en, i_data, i_coefs,
        output o_y, o_sym, o_error, o_valid
    );

endinterface

// File: rtl/sat_trunc.sv
// Arithmetic right shift (floor) followed by saturation to [SAT_MIN, SAT_MAX].
//   data_i  : signed IN_W input
//   sat_c_o : signed OUT_W result (combinational)
module sat_trunc #(
    parameter int unsigned IN_W    = 21,
    parameter int unsigned OUT_W   = 10,
    parameter int unsigned SHIFT   = 7,
    parameter int          SAT_MAX = (1 << (OUT_W - 1)) - 1,
    parameter int          SAT_MIN = -(1 << (OUT_W - 1))
) (
    input  logic signed [IN_W-1:0]  data_i,
    output logic signed [OUT_W-1:0] sat_c_o
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'(SAT_MAX);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(SAT_MIN);

    logic signed [IN_W-1:0] shifted_c;

    assign shifted_c = data_i >>> SHIFT;

    // Clamp, otherwise drop the now-redundant sign bits
    always_comb begin
        sat_c_o = OUT_W'(shifted_c);
        if (shifted_c > MAX_V) begin
            sat_c_o = OUT_W'(MAX_V);
        end else if (shifted_c < MIN_V) begin
            sat_c_o = OUT_W'(MIN_V);
        end
    end

endmodule

// File: rtl/ffe_slicer.sv
// Feed-forward equalizer with PAM2 slicer and error generator.
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : ffe_slicer_if.slave (sample strobe/data, packed taps, results)
// Pipeline: delay line (accept edge) -> products -> sum -> y/sym/error.
module ffe_slicer import eq_pkg::*; (
    input  logic         i_clk,
    input  logic         i_rst,
    ffe_slicer_if.slave  bus
);

    logic signed [DATA_BW-1:0] tap_q [N_COEF];
    logic [FILL_BW-1:0]        fill_q, fill_d;
    logic                      v0_q, v1_q, v2_q, valid_q;
    logic                      v0_d;
    logic signed [ACC_BW-1:0]  sum_q, sum_d;
    ffe_res_t                  res_q, res_d;

    logic signed [Y_BW-1:0]    y_c;
    logic                      sym_c;
    logic signed [DIFF_BW-1:0] diff_c;
    logic signed [ERR_BW-1:0]  err_c;

    // Fill counter saturates at N_COEF; the sample that completes the fill is the first valid one
    always_comb begin
        fill_d = fill_q;
        v0_d   = 1'b0;
        if (bus.i_en) begin
            v0_d = (fill_q >= FILL_BW'(N_COEF - 1));
            if (fill_q != FILL_BW'(N_COEF)) begin
                fill_d = fill_q + FILL_BW'(1);
            end
        end
    end

    // Delay line, fill counter and valid pipeline
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < int'(N_COEF); k++) begin
                tap_q[k] <= '0;
            end
            fill_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (bus.i_en) begin
                tap_q[0] <= bus.i_data;
                for (int k = 1; k < int'(N_COEF); k++) begin
                    tap_q[k] <= tap_q[k-1];
                end
            end
            fill_q  <= fill_d;
            v0_q    <= v0_d;
            v1_q    <= v0_q;
            v2_q    <= v1_q;
            valid_q <= v2_q;
        end
    end

    // Per-tap product registers and the running sign-extended sum chain
    for (genvar k = 0; k < int'(N_COEF); k++) begin : g_tap
        logic signed [COEF_BW-1:0] coef_c;
        logic signed [PROD_BW-1:0] prod_q;
        logic signed [ACC_BW-1:0]  acc_c;

        // Coefficients are taken at the product stage, never earlier
        assign coef_c = bus.i_coefs[COEF_BW*k +: COEF_BW];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                prod_q <= '0;
            end else begin
                prod_q <= PROD_BW'(tap_q[k]) * PROD_BW'(coef_c);
            end
        end

        if (k == 0) begin : g_first
            assign acc_c = ACC_BW'(prod_q);
        end else begin : g_next
            assign acc_c = g_tap[k-1].acc_c + ACC_BW'(prod_q);
        end
    end

    assign sum_d = g_tap[N_COEF-1].acc_c;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    sat_trunc #(
        .IN_W    (ACC_BW),
        .OUT_W   (Y_BW),
        .SHIFT   (FRAC),
        .SAT_MAX (Y_MAX),
        .SAT_MIN (Y_MIN)
    ) u_sat_y (
        .data_i  (sum_q),
        .sat_c_o (y_c)
    );

    // y >= 0 decides +1.0; error is measured against the chosen level
    assign sym_c  = ~y_c[Y_BW-1];
    assign diff_c = DIFF_BW'(y_c) - (sym_c ? DIFF_BW'(ONE) : -DIFF_BW'(ONE));

    sat_trunc #(
        .IN_W    (DIFF_BW),
        .OUT_W   (ERR_BW),
        .SHIFT   (0),
        .SAT_MAX (ERR_MAX),
        .SAT_MIN (ERR_MIN)
    ) u_sat_e (
        .data_i  (diff_c),
        .sat_c_o (err_c)
    );

    // Output stage only loads for a valid result so outputs hold between pulses
    always_comb begin
        res_d = res_q;
        if (v2_q) begin
            res_d.y   = y_c;
            res_d.sym = sym_c;
            res_d.err = err_c;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign bus.o_y     = res_q.y;
    assign bus.o_sym   = res_q.sym;
    assign bus.o_error = res_q.err;
    assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_ffe_slicer.sv
// Scoreboard bench for ffe_slicer: stimulus pushes hand-computed results,
// an independent monitor pops and compares whenever o_valid is seen.
module tb_ffe_slicer;
    import eq_pkg::*;

    typedef struct {
        logic signed [Y_BW-1:0]   y;
        logic                     sym;
        logic signed [ERR_BW-1:0] err;
        int                       cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     fill_m = 0;
    exp_t   sb[$];

    ffe_slicer_if bus();

    ffe_slicer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [COEF_BW*N_COEF-1:0] one_tap(input int k, input int v);
        logic [COEF_BW*N_COEF-1:0] c;
        c = '0;
        c[COEF_BW*k +: COEF_BW] = COEF_BW'(v);
        return c;
    endfunction

    function automatic logic [COEF_BW*N_COEF-1:0] all_taps(input int v);
        logic [COEF_BW*N_COEF-1:0] c;
        c = '0;
        for (int k = 0; k < int'(N_COEF); k++) c[COEF_BW*k +: COEF_BW] = COEF_BW'(v);
        return c;
    endfunction

    // One strobed sample; the result is expected only once N_COEF samples are in
    task automatic send(input int x, input int ey, input int esym, input int ee);
        exp_t e;
        @(posedge clk); #1;
        bus.i_en   = 1'b1;
        bus.i_data = DATA_BW'(x);
        if (fill_m < int'(N_COEF)) fill_m++;
        if (fill_m == int'(N_COEF)) begin
            e.y   = Y_BW'(ey);
            e.sym = 1'(esym);
            e.err = ERR_BW'(ee);
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        bus.i_en = 1'b0;
    endtask

    task automatic restart();
        idle();
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fill_m = 0;
    endtask

    // Monitor: reset values, scoreboard pops, hold between pulses, overdue results
    initial begin : monitor
        exp_t                     e;
        logic signed [Y_BW-1:0]   last_y;
        logic                     last_sym;
        logic signed [ERR_BW-1:0] last_err;
        last_y = '0; last_sym = 1'b0; last_err = '0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                sb.delete();
                last_y = '0; last_sym = 1'b0; last_err = '0;
                checks++;
                if (bus.o_valid !== 1'b0 || bus.o_y !== '0 || bus.o_sym !== 1'b0 || bus.o_error !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: got valid=%0b y=%0d sym=%0b err=%0d, want all 0",
                             bus.o_valid, bus.o_y, bus.o_sym, bus.o_error);
                end
            end else if (bus.o_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, want no result pending", cyc);
                end else begin
                    e = sb.pop_front();
                    if (bus.o_y !== e.y || bus.o_sym !== e.sym || bus.o_error !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result: got y=%0d sym=%0b err=%0d cyc=%0d, want y=%0d sym=%0b err=%0d cyc=%0d",
                                 bus.o_y, bus.o_sym, bus.o_error, cyc, e.y, e.sym, e.err, e.cyc);
                    end
                end
                last_y = bus.o_y; last_sym = bus.o_sym; last_err = bus.o_error;
            end else begin
                checks++;
                if (bus.o_valid !== 1'b0 || bus.o_y !== last_y || bus.o_sym !== last_sym || bus.o_error !== last_err) begin
                    errors++;
                    $display("FAIL hold: got valid=%0b y=%0d sym=%0b err=%0d, want valid=0 y=%0d sym=%0b err=%0d",
                             bus.o_valid, bus.o_y, bus.o_sym, bus.o_error, last_y, last_sym, last_err);
                end
                if (sb.size() > 0) begin
                    checks++;
                    if (cyc >= sb[0].cyc) begin
                        errors++;
                        $display("FAIL missing_valid: got no o_valid by cycle %0d, want result y=%0d at cycle %0d",
                                 cyc, sb[0].y, sb[0].cyc);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    int gx [10] = '{11, 22, 33, 44, 55, 66, 77, 88, 99, -110};
    int gy [10] = '{0, 0, 0, 0, 0, 0, 44, 55, 66, 77};
    int ge [10] = '{0, 0, 0, 0, 0, 0, -84, -73, -62, -51};

    initial begin
        bus.i_en    = 1'b0;
        bus.i_data  = '0;
        bus.i_coefs = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Identity tap at k=3: y(n) = x(n-3)
        bus.i_coefs = one_tap(3, 128);
        repeat (7) send(64, 64, 1, -64);
        send(-100, 64, 1, -64);
        send(30, 64, 1, -64);
        send(5, 64, 1, -64);
        send(-3, -100, 0, 28);
        send(0, 30, 1, -98);
        send(0, 5, 1, -123);
        send(0, -3, 0, 125);

        // Positive saturation of y and error
        restart();
        bus.i_coefs = all_taps(255);
        repeat (8) send(255, 511, 1, 127);

        // Negative saturation of y and error
        restart();
        bus.i_coefs = all_taps(-256);
        repeat (8) send(255, -512, 0, -128);

        // Floor truncation and the y = 0 decision boundary
        restart();
        bus.i_coefs = one_tap(0, 1);
        repeat (6) send(0, 0, 0, 0);
        send(-1, -1, 0, 127);
        send(1, 0, 1, -128);
        send(127, 0, 1, -128);
        send(-128, -1, 0, 127);

        // Strobe every third clock
        restart();
        bus.i_coefs = one_tap(3, 128);
        for (int i = 0; i < 10; i++) begin
            send(gx[i], gy[i], 1, ge[i]);
            idle();
            idle();
        end

        // Coefficients change at the product-capture edge of the 7th sample
        restart();
        bus.i_coefs = one_tap(3, 128);
        repeat (6) send(100, 0, 0, 0);
        send(100, 50, 1, -78);
        @(posedge clk); #1;
        bus.i_en    = 1'b0;
        bus.i_coefs = one_tap(3, 64);
        @(posedge clk); #1;
        bus.i_coefs = one_tap(3, 32);
        send(100, 25, 1, -103);

        // Reset with three results in flight, strobe held during reset
        restart();
        bus.i_coefs = one_tap(3, 128);
        for (int i = 1; i <= 9; i++) send(10 * i, 10 * (i - 3), 1, 10 * (i - 3) - 128);
        @(posedge clk); #1;
        bus.i_en   = 1'b1;
        bus.i_data = DATA_BW'(77);
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        bus.i_en = 1'b0;
        fill_m   = 0;
        for (int i = 1; i <= 8; i++) send(-10 * i, -10 * (i - 3), 0, -10 * (i - 3) + 128);

        idle();
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffe_slicer.md
# ffe_slicer

Feed-forward equalizer datapath with binary slicer and error generator: the consumer of the packed coefficient vector produced by the LMS coefficient updater, and the producer of the error that updater consumes. It filters the received sample stream with the current taps, decides ±1 (PAM2), and emits the equalized sample, decision and saturated error. Together the two blocks close the adaptive equalizer loop.

## Interface
- DATA_BW, 9: input sample width, S(9,7)
- COEF_BW, 9: coefficient width, S(9,7)
- N_COEF, 7: number of taps
- i_clk  in  1  system clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_en  in  1  sample strobe; i_data is accepted on every rising edge where i_en=1
- i_data  in  DATA_BW  received sample x(n), S(9,7)
- i_coefs  in  COEF_BW*N_COEF  packed taps; tap k at bits [COEF_BW*(k+1)-1 : COEF_BW*k], S(9,7)
- o_y  out  10  equalized sample, S(10,7)
- o_sym  out  1  decision: 1 → +1.0, 0 → −1.0
- o_error  out  8  error e = y − d, S(8,7), matches the updater's error input
- o_valid  out  1  one-cycle pulse qualifying o_y/o_sym/o_error

## Operation
- Delay line: N_COEF registers tap[0..N_COEF-1]; on i_en, tap[0]<=i_data, tap[k]<=tap[k-1]. tap[0] is registered (not combinational).
- Fill counter: counts accepted samples, saturates at N_COEF. Results are marked valid only once the counter has reached N_COEF. The first valid output corresponds to the N_COEF-th accepted sample.
- Stage 1 (products): p[k] = tap[k]*c[k], S(18,14), registered. c[k] is sampled from i_coefs at this stage.
- Stage 2 (sum): s = Σ p[k], sign-extended to S(21,14), registered. Full precision, no intermediate rounding.
- Stage 3 (output):
  - y = s >>> 7 (truncate toward −∞), then saturate to [−512, 511] → o_y.
  - o_sym = ~y[9] (y ≥ 0 decides +1).
  - d = +128 or −128.
  - e = y − d in S(11,7), saturated to [−128, 127] → o_error.
- Valid pipeline: v0 = i_en & (fill count reaches N_COEF with this sample). v0 → v1 → v2 → o_valid, advancing every clock. The pipeline is not stalled by i_en=0.
- Data registers of stages 1–3 update every clock. Outputs hold their last values between valid pulses only if a stage-3 update is gated by v2. Gate stage 3 by v2, so o_y/o_sym/o_error hold their values between valid pulses.
- Coefficient change: affects exactly those samples whose stage-1 capture occurs on or after the edge where the new i_coefs is present. No stage after stage 1 is retroactively affected.
- Back-to-back i_en (every clock) is supported at full throughput.

## Timing
- Reset (async, immediate):
  - taps, products, sum, fill counter and v0..v2 cleared to 0.
  - o_y=0, o_sym=0, o_error=0, o_valid=0.
- Latency: sample accepted at edge t → its result is registered at edge t+3. o_valid is high during the cycle after edge t+3 (4 clocks from i_en assertion to o_valid high).
- Reset mid-operation:
  - in-flight results are discarded and no o_valid pulse emerges from them.
  - the fill counter restarts, so N_COEF new samples are needed before the next valid output.
- i_en sampled while i_rst high: ignored.

## Structure
- Shared package `eq_pkg`: DATA_BW/COEF_BW/N_COEF defaults, format constants (Y_BW=10, ERR_BW=8, FRAC=7, ACC_BW=21), ±1.0 constant (128), saturation limits.
- One sub-module: `sat_trunc` (parameterised input width, output width, shift). Instantiated for y (21→10, shift 7) and e (11→8, shift 0).
- Product and sum generated with generate loops over N_COEF.

## Test plan
- Identity taps:
  - Stimulus: c[3]=128, others 0; 7 samples of 64 on consecutive i_en, with 64 arriving as the 4th sample.
  - Required: valid outputs produce o_y=64, o_sym=1, o_error=−64. First o_valid appears exactly 4 clocks after the 7th i_en.
- Positive saturation:
  - Stimulus: all taps 255, data 255.
  - Required: o_y=511, o_sym=1, o_error=127.
- Negative saturation:
  - Stimulus: all taps −256, data 255.
  - Required: o_y=−512, o_sym=0, o_error=−128.
- Truncation:
  - Stimulus: c[0]=1, others 0; sample −1 enters tap[0] (sum −1 in S(21,14)).
  - Required: o_y=−1, o_sym=0, o_error=127.
- Gapped strobes and fill:
  - Stimulus: i_en every 3rd clock.
  - Required: no o_valid before the 7th sample. After that, exactly one o_valid per i_en, each 4 clocks later, and outputs hold between pulses.
- Reset mid-stream:
  - Stimulus: assert i_rst asynchronously with 3 results in flight.
  - Required: all outputs 0 immediately and no stale o_valid. After release, the first o_valid follows the 7th new sample.
